// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//   Digit-serial adder/subtractor. Computes X-Y (mode=0) or X+Y (mode=1) over
//   WIDTH bits, consuming DIGIT bits per clock through a registered carry.
//   Results are held in output registers until the next operation completes.
//
// Parameters
//   WIDTH : operand/result width (>= 2)
//   DIGIT : bits processed per clock; must divide WIDTH. STEPS = WIDTH/DIGIT.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   operation request, honoured in IDLE or DONE only
//   mode     in   0 = subtract, 1 = add (captured with start)
//   X, Y     in   operands (captured with start)
//   busy     out  high while the operation is in flight (RUN)
//   done     out  one-cycle pulse, result fields updated this cycle
//   result   out  difference/sum modulo 2^WIDTH
//   borrow   out  sub: X<Y unsigned; add: carry-out
//   overflow out  two's-complement overflow for the selected mode
// -----------------------------------------------------------------------------
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow,
  output logic             overflow
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_x;        // remaining minuend/augend bits, LSB first
  logic [WIDTH-1:0] r_y;        // remaining Y' bits (already inverted for sub)
  logic [WIDTH-1:0] r_acc;      // partial result, filled from the MSB end
  logic             r_carry;
  logic             r_mode;
  logic             r_xmsb;     // original operand sign bits for overflow
  logic             r_ymsb;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_borrow;
  logic             r_overflow;

  logic [DIGIT:0]   w_sum;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_carry_out;
  logic             w_res_msb;
  logic             w_borrow;
  logic             w_overflow;

  // One digit of the ripple: low DIGIT bits of X and Y' plus the running carry.
  assign w_sum = {1'b0, r_x[DIGIT-1:0]} + {1'b0, r_y[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, r_carry};

  // The newest digit enters at the top so that after STEPS shifts the first
  // (least significant) digit has arrived at bit 0.
  generate
    if (DIGIT == WIDTH) begin : g_single
      assign w_acc_next = w_sum[DIGIT-1:0];
    end else begin : g_multi
      assign w_acc_next = {w_sum[DIGIT-1:0], r_acc[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign w_carry_out = w_sum[DIGIT];
  assign w_res_msb   = w_acc_next[WIDTH-1];
  // Subtraction runs as X + ~Y + 1, so a missing carry-out means a borrow.
  assign w_borrow    = r_mode ? w_carry_out : ~w_carry_out;
  assign w_overflow  = r_mode ? ((r_xmsb == r_ymsb) && (w_res_msb != r_xmsb))
                              : ((r_xmsb != r_ymsb) && (w_res_msb != r_xmsb));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_acc      <= '0;
      r_carry    <= 1'b0;
      r_mode     <= 1'b0;
      r_xmsb     <= 1'b0;
      r_ymsb     <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_borrow   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        // DONE accepts a new request exactly like IDLE (back-to-back ops).
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_x     <= X;
            r_y     <= mode ? Y : ~Y;
            r_carry <= ~mode;
            r_mode  <= mode;
            r_xmsb  <= X[WIDTH-1];
            r_ymsb  <= Y[WIDTH-1];
            r_cnt   <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end

        // start is deliberately not looked at here.
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_x     <= r_x >> DIGIT;
          r_y     <= r_y >> DIGIT;
          r_carry <= w_carry_out;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_result   <= w_acc_next;
            r_borrow   <= w_borrow;
            r_overflow <= w_overflow;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign borrow   = r_borrow;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
//   Two instances: A (WIDTH=4, DIGIT=1) and B (WIDTH=8, DIGIT=4). A timeline
//   model computes expected outputs from plain integer arithmetic; a compare
//   process checks both instances on every falling edge. Directed tests pin
//   the worked examples with literal values.
// -----------------------------------------------------------------------------
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // ---------------- instance A ----------------
  logic       a_start = 1'b0, a_mode = 1'b0;
  logic [3:0] a_x = '0, a_y = '0;
  logic       a_busy, a_done, a_borrow, a_overflow;
  logic [3:0] a_result;

  serial_addsub #(.WIDTH(4), .DIGIT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .mode(a_mode), .X(a_x), .Y(a_y),
    .busy(a_busy), .done(a_done), .result(a_result), .borrow(a_borrow),
    .overflow(a_overflow)
  );

  // ---------------- instance B ----------------
  logic       b_start = 1'b0, b_mode = 1'b0;
  logic [7:0] b_x = '0, b_y = '0;
  logic       b_busy, b_done, b_borrow, b_overflow;
  logic [7:0] b_result;

  serial_addsub #(.WIDTH(8), .DIGIT(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .mode(b_mode), .X(b_x), .Y(b_y),
    .busy(b_busy), .done(b_done), .result(b_result), .borrow(b_borrow),
    .overflow(b_overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference arithmetic: returns {overflow, borrow, result[31:0]}.
  function automatic logic [33:0] ref_calc(input int w, input logic [31:0] x,
                                           input logic [31:0] y, input logic m);
    longint modv, ux, uy, sx, sy, full, sfull;
    logic br, ov;
    logic [31:0] r;
    modv = longint'(1) << w;
    ux = longint'(x);
    uy = longint'(y);
    sx = (ux >= modv / 2) ? ux - modv : ux;
    sy = (uy >= modv / 2) ? uy - modv : uy;
    if (m) begin
      full = ux + uy;  sfull = sx + sy;  br = (full >= modv);
    end else begin
      full = ux - uy;  sfull = sx - sy;  br = (ux < uy);
    end
    r  = 32'((full + modv) % modv);
    ov = (sfull < -(modv / 2)) || (sfull > modv / 2 - 1);
    return {ov, br, r};
  endfunction

  // ---------------- timeline models ----------------
  logic        ma_busy, ma_done;  logic [33:0] ma_out;  int ma_left;
  logic [3:0]  ma_px, ma_py;      logic ma_pm;
  logic        mb_busy, mb_done;  logic [33:0] mb_out;  int mb_left;
  logic [7:0]  mb_px, mb_py;      logic mb_pm;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_busy <= 1'b0; ma_done <= 1'b0; ma_out <= '0; ma_left <= 0;
    end else if (ma_busy) begin
      ma_left <= ma_left - 1;
      if (ma_left == 1) begin
        ma_busy <= 1'b0; ma_done <= 1'b1;
        ma_out  <= ref_calc(4, 32'(ma_px), 32'(ma_py), ma_pm);
      end
    end else begin
      ma_done <= 1'b0;
      if (a_start) begin
        ma_px <= a_x; ma_py <= a_y; ma_pm <= a_mode;
        ma_busy <= 1'b1; ma_left <= 4;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_busy <= 1'b0; mb_done <= 1'b0; mb_out <= '0; mb_left <= 0;
    end else if (mb_busy) begin
      mb_left <= mb_left - 1;
      if (mb_left == 1) begin
        mb_busy <= 1'b0; mb_done <= 1'b1;
        mb_out  <= ref_calc(8, 32'(mb_px), 32'(mb_py), mb_pm);
      end
    end else begin
      mb_done <= 1'b0;
      if (b_start) begin
        mb_px <= b_x; mb_py <= b_y; mb_pm <= b_mode;
        mb_busy <= 1'b1; mb_left <= 2;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("A.busy", 32'(a_busy), 32'(ma_busy));
    chk("A.done", 32'(a_done), 32'(ma_done));
    chk("A.result", 32'(a_result), ma_out[31:0]);
    chk("A.borrow", 32'(a_borrow), 32'(ma_out[32]));
    chk("A.overflow", 32'(a_overflow), 32'(ma_out[33]));
    chk("A.busy_and_done", 32'(a_busy & a_done), 32'd0);
    chk("B.busy", 32'(b_busy), 32'(mb_busy));
    chk("B.done", 32'(b_done), 32'(mb_done));
    chk("B.result", 32'(b_result), mb_out[31:0]);
    chk("B.borrow", 32'(b_borrow), 32'(mb_out[32]));
    chk("B.overflow", 32'(b_overflow), 32'(mb_out[33]));
  end

  // ---------------- directed helpers ----------------
  // Single op on A from idle; operands are scrambled right after acceptance.
  task automatic run_a(input string nm, input logic [3:0] x, input logic [3:0] y,
                       input logic m, input logic [3:0] er, input logic ebr,
                       input logic eov);
    int n, bcnt;
    @(negedge clk);
    a_x = x; a_y = y; a_mode = m; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0; a_x = ~x; a_y = ~y; a_mode = ~m;
    n = 1; bcnt = 0;
    while (!a_done && n < 20) begin
      if (a_busy) bcnt++;
      @(negedge clk);
      n++;
    end
    chk({nm, ".latency"}, 32'(n), 32'd5);
    chk({nm, ".busy_cycles"}, 32'(bcnt), 32'd4);
    chk({nm, ".result"}, 32'(a_result), 32'(er));
    chk({nm, ".borrow"}, 32'(a_borrow), 32'(ebr));
    chk({nm, ".overflow"}, 32'(a_overflow), 32'(eov));
    $display("A %s: x=%0d y=%0d mode=%0d -> result=%b borrow=%0d ovf=%0d after %0d cycles",
             nm, x, y, m, a_result, a_borrow, a_overflow, n);
  endtask

  task automatic run_b(input string nm, input logic [7:0] x, input logic [7:0] y,
                       input logic m, input logic [7:0] er, input logic ebr,
                       input logic eov);
    int n;
    @(negedge clk);
    b_x = x; b_y = y; b_mode = m; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0; b_x = 8'($urandom); b_y = 8'($urandom); b_mode = ~m;
    n = 1;
    while (!b_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, ".latency"}, 32'(n), 32'd3);
    chk({nm, ".result"}, 32'(b_result), 32'(er));
    chk({nm, ".borrow"}, 32'(b_borrow), 32'(ebr));
    chk({nm, ".overflow"}, 32'(b_overflow), 32'(eov));
    $display("B %s: x=%0h y=%0h mode=%0d -> result=%h borrow=%0d ovf=%0d after %0d cycles",
             nm, x, y, m, b_result, b_borrow, b_overflow, n);
  endtask

  logic [3:0] bx [3] = '{4'd15, 4'd0, 4'd5};
  logic [3:0] by [3] = '{4'd7, 4'd8, 4'd10};
  logic [3:0] br_res [3] = '{4'b1000, 4'b1000, 4'b1011};
  logic       br_bor [3] = '{1'b0, 1'b1, 1'b1};
  logic       br_ovf [3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    logic [33:0] p;
    int n, dcnt;

    // Pin the reference arithmetic with hand-computed values.
    p = ref_calc(4, 32'd15, 32'd7, 1'b0);  chk("model.15-7", 32'(p), 32'h0_0000_0008);
    p = ref_calc(4, 32'd0, 32'd8, 1'b0);   chk("model.0-8", 32'(p >> 32), 32'd3);
    chk("model.0-8.res", p[31:0], 32'd8);
    p = ref_calc(4, 32'd9, 32'd8, 1'b1);   chk("model.9+8", p[31:0], 32'd1);
    chk("model.9+8.flags", 32'(p >> 32), 32'd3);
    p = ref_calc(8, 32'd0, 32'd1, 1'b0);   chk("model.00-01", p[31:0], 32'hFF);
    chk("model.00-01.flags", 32'(p >> 32), 32'd1);

    // Reset state.
    #3;
    chk("reset.A", {a_busy, a_done, a_result, a_borrow, a_overflow}, 32'd0);
    chk("reset.B", {b_busy, b_done, b_result, b_borrow, b_overflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic ops.
    run_a("sub2-1", 4'd2, 4'd1, 1'b0, 4'b0001, 1'b0, 1'b0);
    run_a("add9+8", 4'd9, 4'd8, 1'b1, 4'b0001, 1'b1, 1'b1);
    run_a("add3+4", 4'd3, 4'd4, 1'b1, 4'b0111, 1'b0, 1'b0);
    run_a("sub7-7", 4'd7, 4'd7, 1'b0, 4'b0000, 1'b0, 1'b0);
    run_b("sub00-01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);

    // Back-to-back subtractions with start held high through DONE.
    @(negedge clk);
    a_x = bx[0]; a_y = by[0]; a_mode = 1'b0; a_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("b2b%0d.accepted", i), 32'(a_busy), 32'd1);
      if (i < 2) begin
        a_x = bx[i+1]; a_y = by[i+1];
      end else begin
        a_start = 1'b0;
      end
      n = 1;
      while (!a_done && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("b2b%0d.latency", i), 32'(n), 32'd5);
      chk($sformatf("b2b%0d.result", i), 32'(a_result), 32'(br_res[i]));
      chk($sformatf("b2b%0d.borrow", i), 32'(a_borrow), 32'(br_bor[i]));
      chk($sformatf("b2b%0d.overflow", i), 32'(a_overflow), 32'(br_ovf[i]));
      $display("A b2b%0d: %0d-%0d -> result=%b borrow=%0d ovf=%0d", i, bx[i], by[i],
               a_result, a_borrow, a_overflow);
    end

    // start pulsed during RUN is ignored.
    @(negedge clk);
    a_x = 4'd6; a_y = 4'd3; a_mode = 1'b0; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    @(negedge clk);
    a_x = 4'd1; a_y = 4'd9; a_mode = 1'b1; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_done) begin
        dcnt++;
        chk("ignore.result", 32'(a_result), 32'd3);
        chk("ignore.flags", {a_borrow, a_overflow}, 32'd0);
      end
    end
    chk("ignore.done_pulses", 32'(dcnt), 32'd1);
    $display("A ignore-start: 6-3 with extra start -> %0d done pulse(s), result=%b", dcnt, a_result);

    // Asynchronous reset between edges in the middle of RUN.
    @(negedge clk);
    a_x = 4'd12; a_y = 4'd5; a_mode = 1'b1; a_start = 1'b1;
    b_x = 8'h5A; b_y = 8'h33; b_mode = 1'b0; b_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0; b_start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.A", {a_busy, a_done, a_result, a_borrow, a_overflow}, 32'd0);
    chk("async_rst.B", {b_busy, b_done, b_result, b_borrow, b_overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_done || b_done) dcnt++;
    end
    chk("async_rst.no_done", 32'(dcnt), 32'd0);
    $display("async reset mid-run: outputs cleared, %0d done pulse(s) afterwards", dcnt);
    run_a("post_rst_add3+4", 4'd3, 4'd4, 1'b1, 4'b0111, 1'b0, 1'b0);
    run_b("post_rst_sub80-01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      a_start = ($urandom_range(2) == 0);
      a_mode  = 1'($urandom);
      a_x     = 4'($urandom);
      a_y     = 4'($urandom);
      b_start = ($urandom_range(2) == 0);
      b_mode  = 1'($urandom);
      b_x     = 8'($urandom);
      b_y     = 8'($urandom);
      if (a_done)
        $display("A rand: result=%b borrow=%0d ovf=%0d", a_result, a_borrow, a_overflow);
      if (b_done)
        $display("B rand: result=%h borrow=%0d ovf=%0d", b_result, b_borrow, b_overflow);
    end
    @(negedge clk);
    a_start = 1'b0; b_start = 1'b0;
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Safety net: never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
